// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared types and helpers for the perceptron layer.
//   state_t  - layer FSM states
//   idx_w    - index width for a table of n entries (never below 1 bit)
//   sat_relu - clamp a wide signed value into a DATA_W signed range,
//              optionally zeroing negatives
package perceptron_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_IN_DEF   = 784;
    localparam int N_OUT_DEF  = 4;
    localparam int CNT_W_DEF  = idx_w(N_IN_DEF);
    localparam int LANE_W_DEF = idx_w(N_OUT_DEF);

    // Works on a 64-bit carrier so one function serves every lane width;
    // the caller truncates the result back to data_w bits.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                    input int data_w,
                                                    input bit relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (v > hi)      r = hi;
        else if (v < lo) r = lo;
        else             r = v;
        if (relu && r < 0) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/perceptron_lane.sv
// perceptron_lane: one neuron of the layer.
//   w_we/w_addr/w_data : weight RAM write port (already qualified by the top)
//   b_we/b_data        : bias register write
//   clr                : clear accumulator at inference start
//   rd_addr            : weight read address (beat counter), 1-cycle read
//   mac_en/x_q         : registered beat valid and sample, aligned with w_q
//   y                  : rounded, saturated, optionally rectified result
module perceptron_lane import perceptron_pkg::*; #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int N_IN    = 784,
    parameter int ACC_W   = 40,
    parameter int RELU_EN = 1,
    localparam int CNT_W  = idx_w(N_IN)
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_aresetn,
    input  logic                     w_we,
    input  logic [CNT_W-1:0]         w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     b_we,
    input  logic [DATA_W-1:0]        b_data,
    input  logic                     clr,
    input  logic [CNT_W-1:0]         rd_addr,
    input  logic                     mac_en,
    input  logic signed [DATA_W-1:0] x_q,
    output logic [DATA_W-1:0]        y
);

    logic signed [DATA_W-1:0]   mem [N_IN];
    logic signed [DATA_W-1:0]   w_q;
    logic signed [DATA_W-1:0]   bias_q;
    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    r;

    // No reset on the RAM so it maps onto block memory.
    always_ff @(posedge s_axi_aclk) begin
        if (w_we) mem[w_addr] <= w_data;
        w_q <= mem[rd_addr];
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)  bias_q <= '0;
        else if (b_we)       bias_q <= b_data;
    end

    assign prod = x_q * w_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) acc <= '0;
        else if (clr)       acc <= '0;
        else if (mac_en)    acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end

    // Bias is in the sample format; align it with the Q2F product sum.
    assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    assign sum      = acc + (bias_ext <<< FRAC_W);
    assign r        = sum >>> FRAC_W;
    assign y        = DATA_W'(sat_relu(64'(r), DATA_W, RELU_EN != 0));

endmodule

// File: rtl/perceptron_layer.sv
// perceptron_layer: N_OUT neurons over one shared AXI-Stream input vector.
//   s_axi_aclk/s_axi_aresetn : clock, async active-low reset
//   w_wr_* / b_wr_*          : weight/bias load (IDLE and OUT only)
//   start                    : begin an inference (sampled in IDLE)
//   x_t*                     : input samples, N_IN beats per inference
//   y_t*                     : packed lane results, lane k at [k*DATA_W +: DATA_W]
//   busy/len_err/wr_err      : status
module perceptron_layer import perceptron_pkg::*; #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int N_IN    = 784,
    parameter int N_OUT   = 4,
    parameter int ACC_W   = 40,
    parameter int RELU_EN = 1,
    localparam int CNT_W  = idx_w(N_IN),
    localparam int LANE_W = idx_w(N_OUT)
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    w_wr_en,
    input  logic [LANE_W-1:0]       w_wr_lane,
    input  logic [CNT_W-1:0]        w_wr_addr,
    input  logic [DATA_W-1:0]       w_wr_data,
    input  logic                    b_wr_en,
    input  logic [DATA_W-1:0]       b_wr_data,
    input  logic                    start,
    input  logic [DATA_W-1:0]       x_tdata,
    input  logic                    x_tvalid,
    input  logic                    x_tlast,
    output logic                    x_tready,
    output logic [N_OUT*DATA_W-1:0] y_tdata,
    output logic                    y_tvalid,
    input  logic                    y_tready,
    output logic                    busy,
    output logic                    len_err,
    output logic                    wr_err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

    state_t                          state, state_nxt;
    logic [CNT_W-1:0]                cnt;
    logic                            accept, is_last, start_ok, wr_open;
    logic                            vld_q;
    logic signed [DATA_W-1:0]        x_q;
    logic [N_OUT-1:0][DATA_W-1:0]    lane_y;

    assign x_tready = (state == RUN);
    assign busy     = (state != IDLE);
    assign accept   = x_tvalid && x_tready;
    assign is_last  = (cnt == LAST);
    assign start_ok = (state == IDLE) && start;
    assign wr_open  = (state == IDLE) || (state == OUT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)              state_nxt = RUN;
            RUN:     if (accept && is_last)  state_nxt = DRAIN;
            DRAIN:                           state_nxt = OUT;
            OUT:     if (y_tvalid && y_tready) state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) state <= IDLE;
        else                state <= state_nxt;
    end

    // Beat count is authoritative; tlast only feeds the length check.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            cnt     <= '0;
            len_err <= 1'b0;
            vld_q   <= 1'b0;
            x_q     <= '0;
            wr_err  <= 1'b0;
        end else begin
            vld_q  <= accept;
            wr_err <= (w_wr_en || b_wr_en) && !wr_open;
            if (accept) x_q <= x_tdata;
            if (start_ok) begin
                cnt     <= '0;
                len_err <= 1'b0;
            end else if (accept) begin
                cnt <= is_last ? '0 : cnt + 1'b1;
                if (x_tlast != is_last) len_err <= 1'b1;
            end
        end
    end

    // OUT is entered the edge the last product lands in the accumulator, so
    // the result is captured one edge later and then held until the handshake.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            y_tvalid <= 1'b0;
            y_tdata  <= '0;
        end else if (y_tvalid && y_tready) begin
            y_tvalid <= 1'b0;
        end else if (state == OUT && !y_tvalid) begin
            y_tvalid <= 1'b1;
            y_tdata  <= lane_y;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        perceptron_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .N_IN   (N_IN),
            .ACC_W  (ACC_W),
            .RELU_EN(RELU_EN)
        ) u_lane (
            .s_axi_aclk   (s_axi_aclk),
            .s_axi_aresetn(s_axi_aresetn),
            .w_we         (w_wr_en && wr_open && (w_wr_lane == LANE_W'(k))),
            .w_addr       (w_wr_addr),
            .w_data       (w_wr_data),
            .b_we         (b_wr_en && wr_open && (w_wr_lane == LANE_W'(k))),
            .b_data       (b_wr_data),
            .clr          (start_ok),
            .rd_addr      (cnt),
            .mac_en       (vld_q),
            .x_q          (x_q),
            .y            (lane_y[k])
        );
    end

endmodule

// File: tb/tb_perceptron_layer.sv
// tb_perceptron_layer: three layer instances (FRAC_W/RELU_EN = 0/1, 8/0, 0/0)
// share one stimulus stream; every result is compared with a dot-product
// model evaluated directly from the fixed-point rules.
module tb_perceptron_layer;

    localparam int DW = 16;
    localparam int NI = 5;
    localparam int NO = 2;
    localparam int AW = 40;
    localparam int NG = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              w_wr_en, b_wr_en, start, x_tvalid, x_tlast, y_tready;
    logic [0:0]        w_wr_lane;
    logic [2:0]        w_wr_addr;
    logic [DW-1:0]     w_wr_data, b_wr_data, x_tdata;

    logic              xr [NG];
    logic              yv [NG];
    logic              bz [NG];
    logic              le [NG];
    logic              we [NG];
    logic [NO*DW-1:0]  yd [NG];

    int W [NO][NI];
    int Bv[NO];
    int X [NI];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NG; g++) begin : g_dut
        perceptron_layer #(
            .DATA_W(DW), .FRAC_W(g == 1 ? 8 : 0), .N_IN(NI), .N_OUT(NO),
            .ACC_W(AW), .RELU_EN(g == 0 ? 1 : 0)
        ) u_dut (
            .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
            .w_wr_en(w_wr_en), .w_wr_lane(w_wr_lane), .w_wr_addr(w_wr_addr),
            .w_wr_data(w_wr_data), .b_wr_en(b_wr_en), .b_wr_data(b_wr_data),
            .start(start), .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tlast(x_tlast),
            .x_tready(xr[g]), .y_tdata(yd[g]), .y_tvalid(yv[g]), .y_tready(y_tready),
            .busy(bz[g]), .len_err(le[g]), .wr_err(we[g])
        );
    end

    // Reference: full-precision dot product, bias scaled into the product
    // format, floor shift, clamp, optional rectification.
    function automatic int expv(input int g, input int lane);
        int     frac;
        longint acc;
        frac = (g == 1) ? 8 : 0;
        acc  = 0;
        for (int i = 0; i < NI; i++) acc += longint'(X[i]) * longint'(W[lane][i]);
        acc += longint'(Bv[lane]) * (longint'(1) << frac);
        acc  = acc >>> frac;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        if (g == 0 && acc < 0) acc = 0;
        return int'(acc);
    endfunction

    function automatic int lane_of(input int g, input int k);
        return int'($signed(yd[g][k*DW +: DW]));
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic load_all();
        for (int l = 0; l < NO; l++) begin
            for (int i = 0; i < NI; i++) begin
                w_wr_en   = 1'b1;
                w_wr_lane = 1'(l);
                w_wr_addr = 3'(i);
                w_wr_data = 16'(W[l][i]);
                b_wr_en   = (i == 0);          // bias rides along with weight 0
                b_wr_data = 16'(Bv[l]);
                @(negedge clk);
            end
        end
        w_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    // One inference. tlast_at: beat carrying tlast; wr_at: beat during which
    // a (to-be-dropped) weight write is attempted, -1 for none; hold: keep
    // y_tready low for 10 cycles once the result is up.
    task automatic infer(input string tag, input bit gaps, input int tlast_at,
                         input int wr_at, input bit hold);
        int          lat;
        logic [NO*DW-1:0] snap;
        y_tready = !hold;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " x_tready after start"}, xr[0], 1);
        check({tag, " len_err cleared"}, le[0], 0);
        for (int i = 0; i < NI; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin
                x_tvalid = 1'b0;
                @(negedge clk);
            end
            x_tvalid = 1'b1;
            x_tdata  = 16'(X[i]);
            x_tlast  = (i == tlast_at);
            if (i == wr_at) begin
                w_wr_en = 1'b1; w_wr_lane = 1'b0; w_wr_addr = 3'd0; w_wr_data = 16'd99;
            end
            @(negedge clk);
            if (i == wr_at) begin
                w_wr_en = 1'b0;
                check({tag, " wr_err pulse"}, we[0], 1);
            end
        end
        x_tvalid = 1'b0;
        x_tlast  = 1'b0;
        lat = 0;
        while (!yv[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " result latency"}, lat, 2);
        for (int g = 0; g < NG; g++)
            for (int k = 0; k < NO; k++)
                check($sformatf("%s inst%0d lane%0d", tag, g, k), lane_of(g, k), expv(g, k));
        check({tag, " len_err"}, le[0], (tlast_at != NI - 1) ? 1 : 0);
        if (hold) begin
            snap = yd[0];
            repeat (10) begin
                @(negedge clk);
                check({tag, " hold y_tvalid/x_tready"}, {yv[0], xr[0]}, 2'b10);
                check({tag, " hold y_tdata"}, yd[0], snap);
            end
            y_tready = 1'b1;
        end
        @(negedge clk);
        check({tag, " done single beat"}, {yv[0], bz[0]}, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; w_wr_en = 0; b_wr_en = 0; start = 0; x_tvalid = 0; x_tlast = 0;
        y_tready = 1; w_wr_lane = 0; w_wr_addr = 0; w_wr_data = 0; b_wr_data = 0; x_tdata = 0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NG; g++)
            check($sformatf("reset outputs inst%0d", g),
                  {xr[g], yv[g], bz[g], le[g], we[g], yd[g]}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // base case
        for (int i = 0; i < NI; i++) begin
            W[0][i] = i + 1; W[1][i] = -1; X[i] = i + 1;
        end
        Bv = '{1, 1};
        load_all();
        infer("base", 0, NI - 1, -1, 0);
        check("base relu lane0", lane_of(0, 0), 56);
        check("base relu lane1", lane_of(0, 1), 0);
        check("base linear lane1", lane_of(2, 1), -14);

        // saturation both ways
        for (int i = 0; i < NI; i++) begin
            W[0][i] = 32767; W[1][i] = -32767; X[i] = 32767;
        end
        Bv = '{0, 0};
        load_all();
        infer("sat", 0, NI - 1, -1, 0);
        check("sat pos", lane_of(0, 0), 32767);
        check("sat neg", lane_of(2, 1), -32768);

        // fractional: 1.5 * 2.0 = 3.0 in Q8.8
        for (int i = 0; i < NI; i++) begin
            W[0][i] = rnd16(); W[1][i] = rnd16(); X[i] = 0;
        end
        W[0][0] = 'h0200; X[0] = 'h0180; Bv = '{0, rnd16()};
        load_all();
        infer("frac", 0, NI - 1, -1, 0);
        check("frac q8.8 lane0", lane_of(1, 0), 'h0300);

        // random vectors, then the same vector with gaps and back-pressure
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < NI; i++) begin
                W[0][i] = rnd16(); W[1][i] = rnd16(); X[i] = rnd16();
            end
            Bv = '{rnd16(), rnd16()};
            load_all();
            infer($sformatf("rand%0d", t), 0, NI - 1, -1, 0);
            infer($sformatf("rand%0d gaps", t), 1, NI - 1, -1, t == 0);
        end

        // early tlast plus a dropped write during RUN; old weights must survive
        for (int i = 0; i < NI; i++) begin
            W[0][i] = i + 1; W[1][i] = -1; X[i] = i + 1;
        end
        Bv = '{1, 1};
        load_all();
        infer("errs", 0, 2, 1, 0);
        check("errs lane0 old weights", lane_of(0, 0), 56);
        infer("after errs", 0, NI - 1, -1, 0);
        check("after errs lane0", lane_of(0, 0), 56);

        // reset two beats into RUN, with len_err already raised
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_tvalid = 1'b1; x_tdata = 16'd1; x_tlast = 1'b1;
        @(negedge clk);
        x_tdata = 16'd2; x_tlast = 1'b0;
        @(negedge clk);
        x_tvalid = 1'b0;
        check("pre-reset len_err", le[0], 1);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NG; g++)
            check($sformatf("midrun reset inst%0d", g),
                  {xr[g], yv[g], bz[g], le[g], we[g], yd[g]}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // biases were cleared by reset; restore only lane 0
        Bv = '{1, 0};
        b_wr_en = 1'b1; w_wr_lane = 1'b0; b_wr_data = 16'd1;
        @(negedge clk);
        b_wr_en = 1'b0;
        infer("post reset", 0, NI - 1, -1, 0);
        check("post reset lane0", lane_of(0, 0), 56);
        check("post reset linear lane1", lane_of(2, 1), -15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
